display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//  Parametrised, registered N-channel x W-bit display multiplexer with a built-in scan sequencer.
//  Drives a time-multiplexed 7-segment bank from the operations datapath.
//  Selection comes from one of two sources: an external select (manual mode) or an internal
//  prescaled round-robin counter (auto mode).
//  Outputs the selected word plus a one-hot digit-enable and an index.
// PARAMETERS
//  WIDTH        8      bits per channel word
//  CHANNELS     4      number of input channels (>=1, need not be a power of 2)
//  PRESCALE     50000  clk cycles per scan slot in auto mode (>=1)
//  BLANK_CYCLES 4      blanking clocks at the start of each slot; used only with the macro; must be < PRESCALE
//  SEL_W        local  (CHANNELS>1) ? $clog2(CHANNELS) : 1
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  data_in    in   CHANNELS*WIDTH  packed channels, ch0 in [WIDTH-1:0]
//  enable     in   1               0 = display dark, scan frozen
//  mode       in   1               0 = manual (sel_in), 1 = auto scan
//  sel_in     in   SEL_W           manual channel select
//  data_out   out  WIDTH           registered selected word
//  ch_onehot  out  CHANNELS        registered digit enable, bit ch_idx set
//  ch_idx     out  SEL_W           current channel index
//  tick       out  1               1-cycle pulse on every ch_idx change
// BEHAVIOUR
//  Reset (async assert, sync release): data_out=0, ch_onehot=0, ch_idx=0, tick=0, prescaler=0, state=IDLE.
//  States:
//   - IDLE: enable=0.
//   - MANUAL: enable=1, mode=0.
//   - SCAN: enable=1, mode=1.
//   - Any state -> IDLE when enable=0; IDLE -> MANUAL/SCAN per mode when enable=1.
//   - MANUAL <-> SCAN is a direct transition whenever mode changes.
//  IDLE: prescaler and ch_idx hold; data_out=0 and ch_onehot=0 from the next edge; tick=0.
//  MANUAL:
//   - ch_idx <= sel_in each edge; sel_in >= CHANNELS clamps to CHANNELS-1.
//   - Prescaler is held at 0.
//  SCAN:
//   - Prescaler counts 0..PRESCALE-1.
//   - At terminal count the prescaler wraps to 0 and ch_idx <= (ch_idx==CHANNELS-1) ? 0 : ch_idx+1.
//  Datapath (MANUAL/SCAN): data_out <= data_in slice[ch_idx_next] and ch_onehot <= 1<<ch_idx_next.
//   - These register on the same edge as ch_idx, so index, word and enable stay coherent.
//   - Latency from a data_in change to data_out is one cycle.
//  tick is registered; it is 1 for exactly the cycle in which the new ch_idx is first visible.
//  Entering SCAN (from MANUAL or IDLE): scanning resumes from the current ch_idx with prescaler=0.
//  Edge cases:
//   - CHANNELS=1: ch_idx is always 0 and tick never fires.
//   - PRESCALE=1: ch_idx advances every cycle.
//  Reset asserted mid-slot: all outputs return to reset values immediately.
// CONFIGURATION
//  Macro DISPLAY_SCAN_MUX_BLANK_EN.
//   - Defined: during the first BLANK_CYCLES clocks of every slot after a ch_idx change, ch_onehot=0.
//     data_out already shows the new word during this window (ghosting suppression).
//     This applies in both MANUAL and SCAN, and adds state BLANK (SCAN/MANUAL -> BLANK -> prior state).
//   - Undefined: no BLANK state; ch_onehot is valid immediately and BLANK_CYCLES is ignored.
// STRUCTURE
//  Package display_scan_pkg holds:
//   - typedef enum state_t {IDLE, MANUAL, SCAN, BLANK}
//   - MODE_MANUAL=1'b0, MODE_AUTO=1'b1
//   - function sel_width(n)
//  Sub-module scan_prescaler (parameter PRESCALE; inputs clk, rst_n, run, clr; output term): the slot counter.
// TESTING
//  T1 reset: hold rst_n=0 mid-run -> all outputs 0 asynchronously; release -> IDLE; outputs remain 0.
//  T2 manual: data_in={8'hDD,8'hCC,8'hBB,8'hAA}, enable=1, mode=0, sel_in=2 ->
//     next edge: data_out=CC, ch_onehot=0100, tick=1 for one cycle.
//  T3 auto wrap: PRESCALE=3, CHANNELS=3, mode=1 -> ch_idx 0,1,2,0 every 3 clocks; tick=1 on each change.
//  T4 clamp/non-pow2: CHANNELS=3, manual sel_in=3 -> ch_idx=2, data_out=ch2 word.
//  T5 enable drop mid-slot: enable=0 -> data_out=0, ch_onehot=0, ch_idx held;
//     enable=1 -> resumes at the same ch_idx with prescaler restarted.
//  T6 macro on, BLANK_CYCLES=2: on each slot change ch_onehot=0 for 2 clocks while data_out already holds the new word.

Source files
------------

// File: rtl/display_scan_pkg.sv
// ---------------------------------------------------------------------------
// display_scan_pkg
//   Shared types and helpers for the display scan multiplexer.
//   - state_t     : controller states (BLANK only reachable when blanking is built in)
//   - MODE_*      : encodings of the mode input
//   - sel_width() : width of a channel index for n channels (never below 1)
// ---------------------------------------------------------------------------
package display_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2,
      BLANK  = 2'd3
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// ---------------------------------------------------------------------------
// display_scan_mux_if
//   Bus between the operations datapath (master) and the scan multiplexer
//   (slave).
//   Parameters: WIDTH (bits per channel word), CHANNELS (channel count).
//   Signals:
//     data_in   [CHANNELS*WIDTH] packed channel words, ch0 in the low bits
//     enable                     0 = display dark and scan frozen
//     mode                       0 = manual select, 1 = auto scan
//     sel_in    [SEL_W]          manual channel select
//     data_out  [WIDTH]          registered selected word
//     ch_onehot [CHANNELS]       registered digit enable
//     ch_idx    [SEL_W]          current channel index
//     tick                       one-cycle pulse on every ch_idx change
// ---------------------------------------------------------------------------
interface display_scan_mux_if
   import display_scan_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = sel_width(CHANNELS);

   logic [CHANNELS*WIDTH-1:0] data_in;
   logic                      enable;
   logic                      mode;
   logic [SEL_W-1:0]          sel_in;
   logic [WIDTH-1:0]          data_out;
   logic [CHANNELS-1:0]       ch_onehot;
   logic [SEL_W-1:0]          ch_idx;
   logic                      tick;

   modport master (
      output data_in, enable, mode, sel_in,
      input  data_out, ch_onehot, ch_idx, tick
   );

   modport slave (
      input  data_in, enable, mode, sel_in,
      output data_out, ch_onehot, ch_idx, tick
   );

endinterface

// File: rtl/scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
//   Slot counter for the auto-scan sequencer. Counts 0..PRESCALE-1 while
//   run is high and wraps; term is high during the last count of a slot
//   (only while running). clr forces the count back to 0 and has priority.
//   With neither run nor clr the count holds.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     run    in  advance the count this cycle
//     clr    in  restart the slot at count 0
//     term   out current cycle is the final count of the slot
// ---------------------------------------------------------------------------
module scan_prescaler #(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic term
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          at_last;

   assign at_last = (cnt_q == LAST);
   assign term    = run && at_last;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = at_last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// ---------------------------------------------------------------------------
// display_scan_mux
//   Registered N-channel x W-bit display multiplexer with a scan sequencer
//   for a time-multiplexed 7-segment bank. The channel comes either from
//   sel_in (manual) or from a prescaled round-robin counter (auto). Word,
//   one-hot digit enable and index all register on the same edge so they
//   never disagree.
//   Parameters: WIDTH, CHANNELS, PRESCALE (clocks per auto slot),
//               BLANK_CYCLES (digit-off clocks per slot, blanking build only)
//   Ports:
//     clk    in     rising-edge clock
//     rst_n  in     asynchronous active-low reset
//     bus    slave  display_scan_mux_if (data/select in, word/enable/index out)
//   Build option: define DISPLAY_SCAN_MUX_BLANK_EN to hold ch_onehot low for
//   the first BLANK_CYCLES clocks after every index change (ghosting
//   suppression). Without it ch_onehot follows the index immediately.
// ---------------------------------------------------------------------------
module display_scan_mux
   import display_scan_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CHANNELS     = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 4
) (
   input logic              clk,
   input logic              rst_n,
   display_scan_mux_if.slave bus
);
   localparam int SEL_W = sel_width(CHANNELS);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     ch_idx_q, ch_idx_d;
   logic [WIDTH-1:0]     data_out_q, data_out_d;
   logic [CHANNELS-1:0]  onehot_q, onehot_d;
   logic                 tick_q, tick_d;

   logic [WIDTH-1:0]     ch_word [CHANNELS];
   logic [SEL_W-1:0]     sel_clamped;
   logic [SEL_W-1:0]     idx_inc;
   logic                 in_scan_state;
   logic                 scanning;
   logic                 pre_clr;
   logic                 pre_term;
   logic                 idx_change;

`ifdef DISPLAY_SCAN_MUX_BLANK_EN
   logic [31:0]          blank_cnt_q, blank_cnt_d;
   // Mode seen on the previous edge: tells BLANK which slot kind it sits in.
   logic                 ret_q;
`endif

   // Unpack the channel words.
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         assign ch_word[gi] = bus.data_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Out-of-range manual selects pin to the last channel (non power-of-2 banks).
   assign sel_clamped = (int'(bus.sel_in) >= CHANNELS) ? LAST_IDX : bus.sel_in;
   assign idx_inc     = (ch_idx_q == LAST_IDX) ? '0 : ch_idx_q + SEL_W'(1);

`ifdef DISPLAY_SCAN_MUX_BLANK_EN
   assign in_scan_state = (state_q == SCAN) || ((state_q == BLANK) && (ret_q == MODE_AUTO));
`else
   assign in_scan_state = (state_q == SCAN);
`endif

   // The slot only counts once we are actually in a scan slot; the edge that
   // enters SCAN (from IDLE or MANUAL) clears it so scanning restarts at 0.
   // With enable low, run and clr are both low and the count holds.
   assign scanning = bus.enable && (bus.mode == MODE_AUTO) && in_scan_state;
   assign pre_clr  = bus.enable && !scanning;

   scan_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (scanning),
      .clr   (pre_clr),
      .term  (pre_term)
   );

   // Next channel index.
   always_comb begin
      ch_idx_d = ch_idx_q;
      if (bus.enable) begin
         if (bus.mode == MODE_MANUAL) begin
            ch_idx_d = sel_clamped;
         end else if (pre_term) begin
            ch_idx_d = idx_inc;
         end
      end
   end

   assign idx_change = (ch_idx_d != ch_idx_q);

   // Next state.
   always_comb begin
      state_d = state_q;
      if (!bus.enable) begin
         state_d = IDLE;
      end else begin
`ifdef DISPLAY_SCAN_MUX_BLANK_EN
         if (idx_change && (BLANK_CYCLES > 0)) begin
            state_d = BLANK;
         end else if ((state_q == BLANK) && (blank_cnt_q < 32'(BLANK_CYCLES - 1))) begin
            state_d = BLANK;
         end else begin
            state_d = (bus.mode == MODE_AUTO) ? SCAN : MANUAL;
         end
`else
         state_d = (bus.mode == MODE_AUTO) ? SCAN : MANUAL;
`endif
      end
   end

`ifdef DISPLAY_SCAN_MUX_BLANK_EN
   // Blank counter restarts on entry to BLANK and on any index change inside it.
   always_comb begin
      blank_cnt_d = '0;
      if ((state_d == BLANK) && (state_q == BLANK) && !idx_change) begin
         blank_cnt_d = blank_cnt_q + 32'd1;
      end
   end
`endif

   // Registered datapath, computed from the next index so it lands with ch_idx.
   always_comb begin
      data_out_d = '0;
      onehot_d   = '0;
      tick_d     = idx_change;
      if (bus.enable) begin
         data_out_d = ch_word[ch_idx_d];
         onehot_d   = CHANNELS'(1) << ch_idx_d;
`ifdef DISPLAY_SCAN_MUX_BLANK_EN
         if (state_d == BLANK) begin
            onehot_d = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ch_idx_q   <= '0;
         data_out_q <= '0;
         onehot_q   <= '0;
         tick_q     <= 1'b0;
`ifdef DISPLAY_SCAN_MUX_BLANK_EN
         blank_cnt_q <= '0;
         ret_q       <= MODE_MANUAL;
`endif
      end else begin
         state_q    <= state_d;
         ch_idx_q   <= ch_idx_d;
         data_out_q <= data_out_d;
         onehot_q   <= onehot_d;
         tick_q     <= tick_d;
`ifdef DISPLAY_SCAN_MUX_BLANK_EN
         blank_cnt_q <= blank_cnt_d;
         ret_q       <= bus.mode;
`endif
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.ch_onehot = onehot_q;
   assign bus.ch_idx    = ch_idx_q;
   assign bus.tick      = tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_display_scan_mux
//   Directed bench for display_scan_mux. dut_a: 4 x 8-bit, manual-mode work.
//   dut_b: 3 x 8-bit with PRESCALE=3 for clamping, auto scan and enable drop.
//   Expected digit enables account for the blanking build when
//   DISPLAY_SCAN_MUX_BLANK_EN is defined (BLANK_CYCLES=2).
// ---------------------------------------------------------------------------
module tb_display_scan_mux;

`ifdef DISPLAY_SCAN_MUX_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   display_scan_mux_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
   display_scan_mux_if #(.WIDTH(8), .CHANNELS(3)) ifb ();

   display_scan_mux #(
      .WIDTH(8), .CHANNELS(4), .PRESCALE(5), .BLANK_CYCLES(2)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   display_scan_mux #(
      .WIDTH(8), .CHANNELS(3), .PRESCALE(3), .BLANK_CYCLES(2)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      ifa.data_in   = '0;
      ifa.enable    = 1'b0;
      ifa.mode      = 1'b0;
      ifa.sel_in    = '0;
      ifb.data_in   = '0;
      ifb.enable    = 1'b0;
      ifb.mode      = 1'b0;
      ifb.sel_in    = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("a_rst_data",   32'(ifa.data_out),  32'h0);
      check("a_rst_onehot", 32'(ifa.ch_onehot), 32'h0);
      check("a_rst_idx",    32'(ifa.ch_idx),    32'h0);
      check("a_rst_tick",   32'(ifa.tick),      32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("a_idle_data",   32'(ifa.data_out),  32'h0);
      check("a_idle_onehot", 32'(ifa.ch_onehot), 32'h0);

      // Manual select of channel 2
      ifa.data_in = 32'hDDCCBBAA;
      ifa.enable  = 1'b1;
      ifa.mode    = 1'b0;
      ifa.sel_in  = 2'd2;
      @(negedge clk);
      check("a_man_data",   32'(ifa.data_out),  32'hCC);
      check("a_man_idx",    32'(ifa.ch_idx),    32'h2);
      check("a_man_tick",   32'(ifa.tick),      32'h1);
      check("a_man_onehot", 32'(ifa.ch_onehot), BLANK_ON ? 32'h0 : 32'h4);
      @(negedge clk);
      check("a_man_tick_gone", 32'(ifa.tick),     32'h0);
      check("a_man_data_hold", 32'(ifa.data_out), 32'hCC);
      @(negedge clk);
      check("a_man_onehot_settled", 32'(ifa.ch_onehot), 32'h4);

      // One-cycle latency from data_in to data_out
      ifa.data_in = 32'hDD11BBAA;
      @(negedge clk);
      check("a_latency_data", 32'(ifa.data_out), 32'h11);

      // Manual reselect
      ifa.sel_in = 2'd1;
      @(negedge clk);
      check("a_resel_data", 32'(ifa.data_out), 32'hBB);
      check("a_resel_idx",  32'(ifa.ch_idx),   32'h1);
      check("a_resel_tick", 32'(ifa.tick),     32'h1);

      // Reset asserted mid-run clears outputs without waiting for a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("a_async_data",   32'(ifa.data_out),  32'h0);
      check("a_async_onehot", 32'(ifa.ch_onehot), 32'h0);
      check("a_async_idx",    32'(ifa.ch_idx),    32'h0);
      @(negedge clk);
      rst_n      = 1'b1;
      ifa.enable = 1'b0;
      @(negedge clk);
      check("a_post_rst_data", 32'(ifa.data_out), 32'h0);
      check("a_post_rst_idx",  32'(ifa.ch_idx),   32'h0);

      // Clamp on a 3-channel bank: sel_in=3 selects channel 2
      ifb.data_in = 24'h332211;
      ifb.enable  = 1'b1;
      ifb.mode    = 1'b0;
      ifb.sel_in  = 2'd3;
      @(negedge clk);
      check("b_clamp_idx",  32'(ifb.ch_idx),   32'h2);
      check("b_clamp_data", 32'(ifb.data_out), 32'h33);
      check("b_clamp_tick", 32'(ifb.tick),     32'h1);
      ifb.sel_in = 2'd0;
      @(negedge clk);
      check("b_sel0_idx",  32'(ifb.ch_idx),   32'h0);
      check("b_sel0_data", 32'(ifb.data_out), 32'h11);
      repeat (2) @(negedge clk);
      check("b_sel0_onehot", 32'(ifb.ch_onehot), 32'h1);

      // Auto scan: entry edge clears the slot, then 3 clocks per channel
      ifb.mode = 1'b1;
      repeat (3) @(negedge clk);
      check("b_scan_entry_idx",  32'(ifb.ch_idx), 32'h0);
      check("b_scan_entry_tick", 32'(ifb.tick),   32'h0);
      @(negedge clk);
      check("b_scan1_idx",  32'(ifb.ch_idx),   32'h1);
      check("b_scan1_tick", 32'(ifb.tick),     32'h1);
      check("b_scan1_data", 32'(ifb.data_out), 32'h22);
      @(negedge clk);
      check("b_scan1_tick_gone", 32'(ifb.tick), 32'h0);
      @(negedge clk);
      check("b_scan1_onehot", 32'(ifb.ch_onehot), 32'h2);
      @(negedge clk);
      check("b_scan2_idx",    32'(ifb.ch_idx),    32'h2);
      check("b_scan2_tick",   32'(ifb.tick),      32'h1);
      check("b_scan2_data",   32'(ifb.data_out),  32'h33);
      check("b_scan2_onehot", 32'(ifb.ch_onehot), BLANK_ON ? 32'h0 : 32'h4);
      repeat (2) @(negedge clk);
      check("b_scan2_hold_idx",    32'(ifb.ch_idx),    32'h2);
      check("b_scan2_hold_onehot", 32'(ifb.ch_onehot), 32'h4);
      @(negedge clk);
      check("b_wrap_idx",    32'(ifb.ch_idx),    32'h0);
      check("b_wrap_tick",   32'(ifb.tick),      32'h1);
      check("b_wrap_data",   32'(ifb.data_out),  32'h11);
      check("b_wrap_onehot", 32'(ifb.ch_onehot), BLANK_ON ? 32'h0 : 32'h1);
      @(negedge clk);
      check("b_wrap_tick_gone", 32'(ifb.tick),      32'h0);
      check("b_wrap_onehot2",   32'(ifb.ch_onehot), BLANK_ON ? 32'h0 : 32'h1);
      check("b_wrap_data2",     32'(ifb.data_out),  32'h11);

      // Enable dropped mid-slot: dark outputs, index held
      ifb.enable = 1'b0;
      @(negedge clk);
      check("b_off_data",   32'(ifb.data_out),  32'h0);
      check("b_off_onehot", 32'(ifb.ch_onehot), 32'h0);
      check("b_off_idx",    32'(ifb.ch_idx),    32'h0);
      check("b_off_tick",   32'(ifb.tick),      32'h0);
      repeat (3) @(negedge clk);
      check("b_off_idx_held", 32'(ifb.ch_idx), 32'h0);

      // Re-enable: same channel, slot counted from 0 again
      ifb.enable = 1'b1;
      @(negedge clk);
      check("b_on_data",   32'(ifb.data_out),  32'h11);
      check("b_on_onehot", 32'(ifb.ch_onehot), 32'h1);
      check("b_on_idx",    32'(ifb.ch_idx),    32'h0);
      check("b_on_tick",   32'(ifb.tick),      32'h0);
      repeat (2) @(negedge clk);
      check("b_on_slot_idx", 32'(ifb.ch_idx), 32'h0);
      @(negedge clk);
      check("b_on_adv_idx",  32'(ifb.ch_idx),   32'h1);
      check("b_on_adv_tick", 32'(ifb.tick),     32'h1);
      check("b_on_adv_data", 32'(ifb.data_out), 32'h22);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
